// File: rtl/inert_ptch_src.sv
// inert_ptch_src: configures the inertial sensor over an SPI monarch, reads pitch rate
// (and accel-Z when INERT_FUSION_EN is defined) on each sensor INT, integrates the
// offset-compensated rate into signed pitch, and pulses vld toward the PID.
// Optional feature macro: INERT_FUSION_EN (accel-Z leak toward the accelerometer pitch).
module inert_ptch_src #(
  parameter int unsigned INIT_TMR_W     = 16,
  parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
  parameter logic [15:0] AZ_OFFSET      = 16'h00A0,
  parameter int          FUSION_GAIN    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  output logic [15:0] ptch,
  output logic [15:0] ptch_rt,
  output logic        vld
);

`ifdef INERT_FUSION_EN
  localparam bit FUSION_ON = 1'b1;
`else
  localparam bit FUSION_ON = 1'b0;
`endif

  localparam int unsigned PTCH_INT_W = 27;

  localparam logic [15:0] CMD_RD_PL = 16'hA200;
  localparam logic [15:0] CMD_RD_PH = 16'hA300;
  localparam logic [15:0] CMD_RD_AL = 16'hAC00;
  localparam logic [15:0] CMD_RD_AH = 16'hAD00;

  typedef enum logic [3:0] {
    INIT_WAIT,
    INIT_WR,
    IDLE,
    RD_PL,
    RD_PH,
    RD_AL,
    RD_AH,
    INTEG,
    VLD
  } state_t;

  state_t                        state;
  logic [INIT_TMR_W-1:0]         timer;
  logic [1:0]                    wr_idx;
  logic                          int_s1;
  logic                          int_s2;
  logic [7:0]                    rate_l;
  logic [7:0]                    rate_h;
  logic [7:0]                    az_l;
  logic [7:0]                    az_h;
  logic signed [PTCH_INT_W-1:0]  ptch_int;

  logic [15:0]                   ptch_rt_c;
  logic signed [31:0]            az_diff_c;
  logic signed [31:0]            acc_prod_c;
  logic signed [15:0]            ptch_acc_c;
  logic signed [PTCH_INT_W-1:0]  fus_term_c;
  logic signed [PTCH_INT_W-1:0]  ptch_int_nxt_c;
  logic                          unused_rd_hi;

  assign unused_rd_hi = ^spi_rd_data[15:8];

  // Sensor init writes, issued in index order
  function automatic logic [15:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 16'h0D02;
      2'd1:    init_cmd = 16'h1053;
      2'd2:    init_cmd = 16'h1150;
      default: init_cmd = 16'h1460;
    endcase
  endfunction

  // Compensated rate, accel pitch estimate, leak term and next integrator value
  always_comb begin
    ptch_rt_c      = {rate_h, rate_l} - PTCH_RT_OFFSET;
    az_diff_c      = 32'(signed'({az_h, az_l})) - 32'(signed'(AZ_OFFSET));
    acc_prod_c     = az_diff_c * 32'sd327;
    ptch_acc_c     = 16'(acc_prod_c >>> 13);
    fus_term_c     = '0;
    if (FUSION_ON) begin
      fus_term_c = (ptch_acc_c > $signed(ptch)) ? PTCH_INT_W'(FUSION_GAIN)
                                                : -PTCH_INT_W'(FUSION_GAIN);
    end
    ptch_int_nxt_c = ptch_int - PTCH_INT_W'(signed'(ptch_rt_c)) + fus_term_c;
  end

  // Two-flop synchronizer for the asynchronous data-ready level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_s1 <= 1'b0;
      int_s2 <= 1'b0;
    end else begin
      int_s1 <= INT;
      int_s2 <= int_s1;
    end
  end

  // Sequencer: power-up wait, init writes, per-INT read burst, integrate, publish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT_WAIT;
      timer    <= '0;
      wr_idx   <= 2'd0;
      spi_wrt  <= 1'b0;
      spi_cmd  <= 16'h0000;
      rate_l   <= 8'h00;
      rate_h   <= 8'h00;
      az_l     <= 8'h00;
      az_h     <= 8'h00;
      ptch_int <= '0;
      ptch     <= 16'h0000;
      ptch_rt  <= 16'h0000;
      vld      <= 1'b0;
    end else begin
      spi_wrt <= 1'b0;
      vld     <= 1'b0;
      case (state)
        INIT_WAIT: begin
          if (timer == '1) begin
            state   <= INIT_WR;
            wr_idx  <= 2'd0;
            spi_wrt <= 1'b1;
            spi_cmd <= init_cmd(2'd0);
          end else begin
            timer <= timer + INIT_TMR_W'(1);
          end
        end
        INIT_WR: begin
          if (spi_done) begin
            if (wr_idx == 2'd3) begin
              state <= IDLE;
            end else begin
              wr_idx  <= wr_idx + 2'd1;
              spi_wrt <= 1'b1;
              spi_cmd <= init_cmd(wr_idx + 2'd1);
            end
          end
        end
        IDLE: begin
          if (int_s2) begin
            state   <= RD_PL;
            spi_wrt <= 1'b1;
            spi_cmd <= CMD_RD_PL;
          end
        end
        RD_PL: begin
          if (spi_done) begin
            rate_l  <= spi_rd_data[7:0];
            state   <= RD_PH;
            spi_wrt <= 1'b1;
            spi_cmd <= CMD_RD_PH;
          end
        end
        RD_PH: begin
          if (spi_done) begin
            rate_h <= spi_rd_data[7:0];
            if (FUSION_ON) begin
              state   <= RD_AL;
              spi_wrt <= 1'b1;
              spi_cmd <= CMD_RD_AL;
            end else begin
              state <= INTEG;
            end
          end
        end
        RD_AL: begin
          if (spi_done) begin
            az_l    <= spi_rd_data[7:0];
            state   <= RD_AH;
            spi_wrt <= 1'b1;
            spi_cmd <= CMD_RD_AH;
          end
        end
        RD_AH: begin
          if (spi_done) begin
            az_h  <= spi_rd_data[7:0];
            state <= INTEG;
          end
        end
        INTEG: begin
          ptch_int <= ptch_int_nxt_c;
          ptch     <= ptch_int_nxt_c[26:11];
          ptch_rt  <= ptch_rt_c;
          vld      <= 1'b1;
          state    <= VLD;
        end
        VLD: begin
          state <= IDLE;
        end
        default: begin
          state <= INIT_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inert_ptch_src.sv
// tb_inert_ptch_src: directed bench with an SPI responder returning done 10 clks after wrt.
module tb_inert_ptch_src;

  logic        clk;
  logic        rst_n;
  logic        INT;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd_data;
  logic [15:0] ptch;
  logic [15:0] ptch_rt;
  logic        vld;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int cnt = 0;
  int overlap = 0;
  int vld_cnt = 0;
  int vld_cyc = 0;
  int done_cyc = 0;
  int first_wrt_cyc = 0;
  int rel_cyc = 0;
  bit wrt_seen = 1'b0;
  logic [6:0]  cur_addr;
  logic [15:0] cmd_q[$];
  logic [7:0]  r_l, r_h, a_l, a_h;

  inert_ptch_src #(.INIT_TMR_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .INT         (INT),
    .spi_wrt     (spi_wrt),
    .spi_cmd     (spi_cmd),
    .spi_done    (spi_done),
    .spi_rd_data (spi_rd_data),
    .ptch        (ptch),
    .ptch_rt     (ptch_rt),
    .vld         (vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [7:0] resp_byte(input logic [6:0] addr);
    case (addr)
      7'h22:   resp_byte = r_l;
      7'h23:   resp_byte = r_h;
      7'h2C:   resp_byte = a_l;
      7'h2D:   resp_byte = a_h;
      default: resp_byte = 8'h00;
    endcase
  endfunction

  // SPI responder and event recorder, driven on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt         = 0;
      spi_done    = 1'b0;
      spi_rd_data = 16'h0000;
    end else begin
      spi_done = 1'b0;
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          spi_done    = 1'b1;
          spi_rd_data = {8'h00, resp_byte(cur_addr)};
          done_cyc    = cyc;
        end
      end
      if (spi_wrt) begin
        if (cnt != 0) overlap = overlap + 1;
        cmd_q.push_back(spi_cmd);
        cur_addr = spi_cmd[14:8];
        cnt = 10;
        if (!wrt_seen) begin
          wrt_seen      = 1'b1;
          first_wrt_cyc = cyc;
        end
      end
      if (vld) begin
        vld_cnt = vld_cnt + 1;
        vld_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cmds(input int n, input string tag);
    int b;
    b = 0;
    while (cmd_q.size() < n && b < 400) begin
      @(negedge clk);
      b = b + 1;
    end
    check(tag, 32'(cmd_q.size() >= n), 32'd1);
  endtask

  task automatic sample(input logic [7:0] rl, input logic [7:0] rh,
                        input logic [7:0] al, input logic [7:0] ah);
    int n0;
    int b;
    n0  = vld_cnt;
    r_l = rl;
    r_h = rh;
    a_l = al;
    a_h = ah;
    INT = 1'b1;
    repeat (4) @(negedge clk);
    INT = 1'b0;
    b = 0;
    while (vld_cnt == n0 && b < 300) begin
      @(negedge clk);
      b = b + 1;
    end
    check("vld_seen", 32'(vld_cnt != n0), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base;
    int vbase;
    rst_n = 1'b0;
    INT   = 1'b0;
    r_l = 8'h00; r_h = 8'h00; a_l = 8'h00; a_h = 8'h00;
    spi_done = 1'b0;
    spi_rd_data = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_spi_wrt", 32'(spi_wrt), 32'd0);
    check("rst_spi_cmd", 32'(spi_cmd), 32'd0);
    check("rst_vld",     32'(vld),     32'd0);
    check("rst_ptch",    32'(ptch),    32'd0);
    check("rst_ptch_rt", 32'(ptch_rt), 32'd0);

    // Release reset; hold INT high through most of init, which must be ignored
    rst_n   = 1'b1;
    rel_cyc = cyc;
    repeat (5) @(negedge clk);
    INT = 1'b1;
    wait_cmds(4, "init_cmds_timeout");
    INT = 1'b0;
    repeat (40) @(negedge clk);
    check("init_wait_len", 32'(first_wrt_cyc - rel_cyc), 32'd16);
    check("init_cmd0", 32'(cmd_q[0]), 32'h0D02);
    check("init_cmd1", 32'(cmd_q[1]), 32'h1053);
    check("init_cmd2", 32'(cmd_q[2]), 32'h1150);
    check("init_cmd3", 32'(cmd_q[3]), 32'h1460);
    check("int_ignored_in_init", 32'(cmd_q.size()), 32'd4);
    check("init_no_overlap", 32'(overlap), 32'd0);

`ifdef INERT_FUSION_EN
    // Rate at offset, AZ = offset + 0x100: accel pitch 0x000A pulls ptch up by 1024 per sample
    for (int n = 1; n <= 6; n++) begin
      sample(8'h50, 8'h00, 8'hA0, 8'h01);
      check("fus_ptch", 32'(ptch), 32'((n * 1024) / 2048));
      check("fus_ptch_rt", 32'(ptch_rt), 32'h0000);
    end
    check("fus_cmd_rd_pl", 32'(cmd_q[4]), 32'hA200);
    check("fus_cmd_rd_ph", 32'(cmd_q[5]), 32'hA300);
    check("fus_cmd_rd_al", 32'(cmd_q[6]), 32'hAC00);
    check("fus_cmd_rd_ah", 32'(cmd_q[7]), 32'hAD00);
    check("fus_latency", 32'(vld_cyc - done_cyc), 32'd2);
    check("fus_vld_count", 32'(vld_cnt), 32'd6);
`else
    // Rate equal to offset: nothing integrates
    sample(8'h50, 8'h00, 8'h00, 8'h00);
    check("rd_cmd_pl", 32'(cmd_q[4]), 32'hA200);
    check("rd_cmd_ph", 32'(cmd_q[5]), 32'hA300);
    check("rd_cmd_count", 32'(cmd_q.size()), 32'd6);
    check("zero_ptch_rt", 32'(ptch_rt), 32'h0000);
    check("zero_ptch", 32'(ptch), 32'h0000);
    check("vld_latency", 32'(vld_cyc - done_cyc), 32'd2);
    check("vld_one_clk", 32'(vld_cnt), 32'd1);
    check("vld_low_after", 32'(vld), 32'd0);

    // Rate 0x0150 eight times: ptch_int = -8*256 = -2048
    for (int n = 0; n < 8; n++) sample(8'h50, 8'h01, 8'h00, 8'h00);
    check("gyro_ptch_rt", 32'(ptch_rt), 32'h0100);
    check("gyro_ptch", 32'(ptch), 32'hFFFF);
    check("gyro_cmd_count", 32'(cmd_q.size()), 32'd22);

    // Rate 0: compensated rate wraps to 0xFFB0, ptch_int = -2048 + 80 = -1968
    sample(8'h00, 8'h00, 8'h00, 8'h00);
    check("wrap_ptch_rt", 32'(ptch_rt), 32'hFFB0);
    check("wrap_ptch", 32'(ptch), 32'hFFFF);

    // Rate 0x8050: -32768 compensated, ptch_int = -1968 + 32768 = 30800 -> ptch 15
    sample(8'h50, 8'h80, 8'h00, 8'h00);
    check("neg_ptch_rt", 32'(ptch_rt), 32'h8000);
    check("neg_ptch", 32'(ptch), 32'h000F);
    check("gyro_vld_count", 32'(vld_cnt), 32'd11);
`endif
    check("rd_no_overlap", 32'(overlap), 32'd0);

    // Reset during the rate-high read aborts the burst and restarts init
    base  = cmd_q.size();
    vbase = vld_cnt;
    r_l = 8'h50; r_h = 8'h01;
    INT = 1'b1;
    wait_cmds(base + 2, "mid_rd_timeout");
    INT = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_spi_wrt", 32'(spi_wrt), 32'd0);
    check("mid_rst_vld",     32'(vld),     32'd0);
    check("mid_rst_ptch",    32'(ptch),    32'd0);
    check("mid_rst_ptch_rt", 32'(ptch_rt), 32'd0);
    repeat (2) @(negedge clk);
    cmd_q.delete();
    wrt_seen = 1'b0;
    rst_n    = 1'b1;
    rel_cyc  = cyc;
    wait_cmds(4, "reinit_timeout");
    repeat (15) @(negedge clk);
    check("reinit_wait_len", 32'(first_wrt_cyc - rel_cyc), 32'd16);
    check("reinit_cmd0", 32'(cmd_q[0]), 32'h0D02);
    check("reinit_cmd3", 32'(cmd_q[3]), 32'h1460);
    check("aborted_no_vld", 32'(vld_cnt - vbase), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
